cpu0_mc: RTL and testbench

CPU0_MC -- requirements
Module: cpu0_mc

---
 rtl/cpu0_mc.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu0_mc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu0_mc.sv
// Multi-cycle 32-bit CPU0 subset core: sixteen registers (R15 = PC), N/Z flags and a
// single request/ready memory port. All outputs come straight from registers.
module cpu0_mc #(
    parameter int          AW              = 16,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    output logic          m_en,
    output logic          m_rw,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    input  logic          m_ready,
    output logic [31:0]   pc,
    output logic [31:0]   ir,
    output logic [2:0]    state,
    output logic          halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [7:0] OP_LD  = 8'h00;
    localparam logic [7:0] OP_ST  = 8'h01;
    localparam logic [7:0] OP_CMP = 8'h10;
    localparam logic [7:0] OP_ADD = 8'h13;
    localparam logic [7:0] OP_SUB = 8'h14;
    localparam logic [7:0] OP_JEQ = 8'h20;
    localparam logic [7:0] OP_JNE = 8'h21;
    localparam logic [7:0] OP_JMP = 8'h26;

    state_t        state_r;
    logic [31:0]   regs_r [16];
    logic          flag_n_r;
    logic          flag_z_r;
    logic [31:0]   ir_r;
    logic [31:0]   res_r;
    logic          m_en_r;
    logic          m_rw_r;
    logic [AW-1:0] m_addr_r;
    logic [31:0]   m_wdata_r;
    logic          halted_r;

    logic [7:0]  op_s;
    logic [3:0]  ra_s, rb_s, rc_s;
    logic [31:0] cx16_s, cx24_s;
    logic [31:0] ra_val_s, rb_val_s, rc_val_s, pc_s, pc_inc_s;
    logic [31:0] ea_s, jmp_tgt_s, wb_pc_s;
    logic        taken_s;

    function automatic logic is_legal(input logic [7:0] op);
        case (op)
            OP_LD, OP_ST, OP_CMP, OP_ADD, OP_SUB,
            OP_JEQ, OP_JNE, OP_JMP: is_legal = 1'b1;
            default:                is_legal = 1'b0;
        endcase
    endfunction

    // Instruction field decode and operand/target arithmetic
    always_comb begin
        op_s      = ir_r[31:24];
        ra_s      = ir_r[23:20];
        rb_s      = ir_r[19:16];
        rc_s      = ir_r[15:12];
        cx16_s    = {{16{ir_r[15]}}, ir_r[15:0]};
        cx24_s    = {{8{ir_r[23]}}, ir_r[23:0]};
        ra_val_s  = regs_r[ra_s];
        rb_val_s  = regs_r[rb_s];
        rc_val_s  = regs_r[rc_s];
        pc_s      = regs_r[15];
        pc_inc_s  = pc_s + 32'd4;
        ea_s      = rb_val_s + cx16_s;
        case (op_s)
            OP_JEQ:  taken_s = flag_z_r;
            OP_JNE:  taken_s = ~flag_z_r;
            OP_JMP:  taken_s = 1'b1;
            default: taken_s = 1'b0;
        endcase
        if (taken_s) begin
            jmp_tgt_s = pc_s + cx24_s;
        end else begin
            jmp_tgt_s = pc_s;
        end
        // A register write to R15 redirects the next fetch
        if ((op_s != OP_CMP) && (ra_s == 4'd15)) begin
            wb_pc_s = res_r;
        end else begin
            wb_pc_s = pc_s;
        end
    end

    // Control FSM, register file, flags and memory port registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= ST_FETCH;
            for (int i = 0; i < 15; i++) begin
                regs_r[i] <= 32'd0;
            end
            regs_r[15] <= RESET_PC;
            flag_n_r  <= 1'b0;
            flag_z_r  <= 1'b0;
            ir_r      <= 32'd0;
            res_r     <= 32'd0;
            m_en_r    <= 1'b0;
            m_rw_r    <= 1'b1;
            m_addr_r  <= '0;
            m_wdata_r <= 32'd0;
            halted_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // Only the first fetch after reset has to raise the request here
                    if (!m_en_r) begin
                        m_en_r   <= 1'b1;
                        m_rw_r   <= 1'b1;
                        m_addr_r <= pc_s[AW-1:0];
                    end else if (m_ready) begin
                        ir_r    <= m_rdata;
                        m_en_r  <= 1'b0;
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    regs_r[15] <= pc_inc_s;
                    if (is_legal(op_s)) begin
                        state_r <= ST_EXEC;
                    end else if (HALT_ON_ILLEGAL) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_FETCH;
                        m_en_r   <= 1'b1;
                        m_rw_r   <= 1'b1;
                        m_addr_r <= pc_inc_s[AW-1:0];
                    end
                end
                ST_EXEC: begin
                    case (op_s)
                        OP_LD, OP_ST: begin
                            m_en_r    <= 1'b1;
                            m_rw_r    <= (op_s == OP_LD);
                            m_addr_r  <= ea_s[AW-1:0];
                            m_wdata_r <= ra_val_s;
                            state_r   <= ST_MEM;
                        end
                        OP_ADD: begin
                            res_r   <= rb_val_s + rc_val_s;
                            state_r <= ST_WB;
                        end
                        OP_SUB: begin
                            res_r   <= rb_val_s - rc_val_s;
                            state_r <= ST_WB;
                        end
                        OP_CMP: begin
                            res_r   <= ra_val_s - rb_val_s;
                            state_r <= ST_WB;
                        end
                        default: begin
                            regs_r[15] <= jmp_tgt_s;
                            m_en_r     <= 1'b1;
                            m_rw_r     <= 1'b1;
                            m_addr_r   <= jmp_tgt_s[AW-1:0];
                            state_r    <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (m_ready) begin
                        if (op_s == OP_LD) begin
                            res_r   <= m_rdata;
                            m_en_r  <= 1'b0;
                            state_r <= ST_WB;
                        end else begin
                            m_rw_r   <= 1'b1;
                            m_addr_r <= pc_s[AW-1:0];
                            state_r  <= ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    if (op_s == OP_CMP) begin
                        flag_n_r <= res_r[31];
                        flag_z_r <= (res_r == 32'd0);
                    end else begin
                        regs_r[ra_s] <= res_r;
                    end
                    m_en_r   <= 1'b1;
                    m_rw_r   <= 1'b1;
                    m_addr_r <= wb_pc_s[AW-1:0];
                    state_r  <= ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r  <= ST_HALT;
                    m_en_r   <= 1'b0;
                    halted_r <= 1'b1;
                end
            endcase
        end
    end

    assign m_en    = m_en_r;
    assign m_rw    = m_rw_r;
    assign m_addr  = m_addr_r;
    assign m_wdata = m_wdata_r;
    assign pc      = regs_r[15];
    assign ir      = ir_r;
    assign state   = state_r;
    assign halted  = halted_r;

endmodule

// File: tb/tb_cpu0_mc.sv
// Directed bench for cpu0_mc: a table of single-instruction vectors run as one program,
// then hand-written sequences for the sum loop, fetch stall, halt and reset-during-store.
module tb_cpu0_mc;

    localparam logic [7:0] OP_LD  = 8'h00;
    localparam logic [7:0] OP_ST  = 8'h01;
    localparam logic [7:0] OP_CMP = 8'h10;
    localparam logic [7:0] OP_ADD = 8'h13;
    localparam logic [7:0] OP_SUB = 8'h14;
    localparam logic [7:0] OP_JEQ = 8'h20;
    localparam logic [7:0] OP_JNE = 8'h21;
    localparam logic [7:0] OP_JMP = 8'h26;

    logic        clock;
    logic        reset;
    logic        m_en, m_rw, m_ready, halted;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_rdata, pc, ir;
    logic [2:0]  state;

    logic [7:0]  mem [256];
    logic        pl_we;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    logic [7:0]  ba;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [31:0] ins;
        int          kind;   // 0 reg, 1 memory word, 2 next fetch address, 3 {N,Z}
        int          idx;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs [21];

    cpu0_mc #(.AW(16), .RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clock(clock), .reset(reset), .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .pc(pc), .ir(ir),
        .state(state), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Big-endian byte memory model
    always_comb begin
        ba      = m_addr[7:0];
        m_rdata = {mem[ba], mem[ba + 8'd1], mem[ba + 8'd2], mem[ba + 8'd3]};
    end

    always @(posedge clock) begin
        if (pl_we) begin
            {mem[pl_addr], mem[pl_addr + 8'd1], mem[pl_addr + 8'd2], mem[pl_addr + 8'd3]} <= pl_data;
        end else if (m_en && !m_rw && m_ready) begin
            {mem[ba], mem[ba + 8'd1], mem[ba + 8'd2], mem[ba + 8'd3]} <= m_wdata;
        end
    end

    function automatic logic [31:0] enc_r(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 12'h000};
    endfunction

    function automatic logic [31:0] enc_m(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b, input logic [15:0] imm);
        return {op, a, b, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [7:0] op, input logic [23:0] off);
        return {op, off};
    endfunction

    function automatic vec_t mk(input string n, input logic [7:0] a, input logic [31:0] ins,
                                input int kind, input int idx, input logic [31:0] exp, input int cyc);
        vec_t v;
        v.name = n; v.addr = a; v.ins = ins; v.kind = kind; v.idx = idx; v.exp = exp; v.cyc = cyc;
        return v;
    endfunction

    function automatic logic [31:0] rd_word(input logic [7:0] a);
        return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(negedge clock);
        pl_we   = 1'b0;
    endtask

    // From the first cycle of one fetch, count cycles to the first cycle of the next fetch
    task automatic next_fetch(output int cyc);
        bit left;
        left = 1'b0;
        cyc  = 0;
        while (cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (state != 3'd0) left = 1'b1;
            else if (left && m_en) break;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n;
        n = 0;
        while (state != s && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk(name, {29'd0, state}, {29'd0, s});
    endtask

    initial begin
        int          cyc, tot;
        logic [31:0] r3_exp [6];
        logic [31:0] loop_jmp;
        logic        any_nz;

        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        m_ready = 1'b1;
        pl_we   = 1'b0;
        pl_addr = 8'd0;
        pl_data = 32'd0;
        r3_exp  = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15, 32'd21};
        loop_jmp = enc_j(OP_JMP, 24'hFFFFF4);

        vecs[0]  = mk("ld_r1",     8'h00, enc_m(OP_LD, 4'd1, 4'd0, 16'h0080), 0, 1,  32'd5, 5);
        vecs[1]  = mk("ld_r2",     8'h04, enc_m(OP_LD, 4'd2, 4'd0, 16'h0084), 0, 2,  32'd6, 5);
        vecs[2]  = mk("ld_r5",     8'h08, enc_m(OP_LD, 4'd5, 4'd0, 16'h0088), 0, 5,  32'hDEADBEEF, 5);
        vecs[3]  = mk("ld_r6",     8'h0C, enc_m(OP_LD, 4'd6, 4'd0, 16'h008C), 0, 6,  32'h7FFFFFFF, 5);
        vecs[4]  = mk("add",       8'h10, enc_r(OP_ADD, 4'd7, 4'd1, 4'd2),    0, 7,  32'd11, 4);
        vecs[5]  = mk("sub_neg",   8'h14, enc_r(OP_SUB, 4'd8, 4'd1, 4'd2),    0, 8,  32'hFFFFFFFF, 4);
        vecs[6]  = mk("add_wrap",  8'h18, enc_r(OP_ADD, 4'd9, 4'd6, 4'd1),    0, 9,  32'h80000004, 4);
        vecs[7]  = mk("sub_wrap",  8'h1C, enc_r(OP_SUB, 4'd10, 4'd0, 4'd6),   0, 10, 32'h80000001, 4);
        vecs[8]  = mk("ld_off",    8'h20, enc_m(OP_LD, 4'd11, 4'd2, 16'h0082), 0, 11, 32'hDEADBEEF, 5);
        vecs[9]  = mk("ld_negoff", 8'h24, enc_m(OP_LD, 4'd12, 4'd9, 16'hFFFC), 0, 12, enc_m(OP_LD, 4'd1, 4'd0, 16'h0080), 5);
        vecs[10] = mk("st_mem",    8'h28, enc_m(OP_ST, 4'd5, 4'd0, 16'h00A0), 1, 8'hA0, 32'hDEADBEEF, 4);
        vecs[11] = mk("cmp_eq",    8'h2C, enc_r(OP_CMP, 4'd1, 4'd1, 4'd0),    3, 0,  32'd1, 4);
        vecs[12] = mk("jeq_taken", 8'h30, enc_j(OP_JEQ, 24'h000008),          2, 0,  32'h3C, 3);
        vecs[13] = mk("cmp_lt",    8'h3C, enc_r(OP_CMP, 4'd1, 4'd2, 4'd0),    3, 0,  32'd2, 4);
        vecs[14] = mk("jeq_fall",  8'h40, enc_j(OP_JEQ, 24'h000008),          2, 0,  32'h44, 3);
        vecs[15] = mk("jne_taken", 8'h44, enc_j(OP_JNE, 24'h000004),          2, 0,  32'h4C, 3);
        vecs[16] = mk("ld_back",   8'h4C, enc_m(OP_LD, 4'd4, 4'd0, 16'h00A0), 0, 4,  32'hDEADBEEF, 5);
        vecs[17] = mk("ld_pc",     8'h50, enc_m(OP_LD, 4'd15, 4'd0, 16'h0094), 2, 0, 32'h58, 5);
        vecs[18] = mk("ld_one",    8'h58, enc_m(OP_LD, 4'd1, 4'd0, 16'h0090), 0, 1,  32'd1, 5);
        vecs[19] = mk("ld_zero2",  8'h5C, enc_m(OP_LD, 4'd2, 4'd0, 16'h0098), 0, 2,  32'd0, 5);
        vecs[20] = mk("ld_zero3",  8'h60, enc_m(OP_LD, 4'd3, 4'd0, 16'h0098), 0, 3,  32'd0, 5);

        @(negedge clock);
        foreach (vecs[i]) poke(vecs[i].addr, vecs[i].ins);
        poke(8'h34, 32'hFF000000); poke(8'h38, 32'hFF000000);
        poke(8'h48, 32'hFF000000); poke(8'h54, 32'hFF000000);
        poke(8'h64, enc_r(OP_ADD, 4'd2, 4'd2, 4'd1));
        poke(8'h68, enc_r(OP_ADD, 4'd3, 4'd3, 4'd2));
        poke(8'h6C, loop_jmp);
        poke(8'h80, 32'd5);          poke(8'h84, 32'd6);
        poke(8'h88, 32'hDEADBEEF);   poke(8'h8C, 32'h7FFFFFFF);
        poke(8'h90, 32'd1);          poke(8'h94, 32'h58);
        poke(8'h98, 32'd0);          poke(8'hA0, 32'd0);

        // Reset state
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_m_en", {31'd0, m_en}, 32'd0);
        chk("rst_m_rw", {31'd0, m_rw}, 32'd1);
        chk("rst_m_addr", {16'd0, m_addr}, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_flags", {30'd0, dut.flag_n_r, dut.flag_z_r}, 32'd0);

        reset = 1'b1;
        @(negedge clock);
        chk("first_fetch_en", {31'd0, m_en}, 32'd1);
        chk("first_fetch_addr", {16'd0, m_addr}, 32'd0);
        chk("first_fetch_rw", {31'd0, m_rw}, 32'd1);

        foreach (vecs[i]) begin
            next_fetch(cyc);
            chk({vecs[i].name, "_cycles"}, cyc, vecs[i].cyc);
            case (vecs[i].kind)
                0: chk(vecs[i].name, dut.regs_r[vecs[i].idx], vecs[i].exp);
                1: chk(vecs[i].name, rd_word(vecs[i].idx[7:0]), vecs[i].exp);
                2: begin
                    chk(vecs[i].name, {16'd0, m_addr}, vecs[i].exp);
                    chk({vecs[i].name, "_pc"}, pc, vecs[i].exp);
                end
                default: chk(vecs[i].name, {30'd0, dut.flag_n_r, dut.flag_z_r}, vecs[i].exp);
            endcase
        end
        chk("st_byte0", {24'd0, mem[8'hA0]}, 32'hDE);
        chk("st_byte3", {24'd0, mem[8'hA3]}, 32'hEF);

        // Sum loop: five iterations at full speed
        for (int k = 0; k < 5; k++) begin
            tot = 0;
            for (int j = 0; j < 3; j++) begin
                next_fetch(cyc);
                tot += cyc;
            end
            chk("loop_cycles", tot, 11);
            chk("loop_r3", dut.regs_r[3], r3_exp[k]);
        end

        // Sixth iteration with the first fetch stalled three cycles
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("stall_en", {31'd0, m_en}, 32'd1);
            chk("stall_addr", {16'd0, m_addr}, 32'h64);
            chk("stall_rw", {31'd0, m_rw}, 32'd1);
            chk("stall_ir", ir, loop_jmp);
        end
        m_ready = 1'b1;
        tot = 3;
        for (int j = 0; j < 3; j++) begin
            next_fetch(cyc);
            tot += cyc;
            if (j == 0) chk("stall_ir_new", ir, enc_r(OP_ADD, 4'd2, 4'd2, 4'd1));
        end
        chk("stall_loop_cycles", tot, 14);
        chk("stall_loop_r3", dut.regs_r[3], r3_exp[5]);

        // Illegal opcode halts until reset
        reset = 1'b0;
        @(negedge clock);
        poke(8'h00, 32'hFF000000);
        reset = 1'b1;
        wait_state(3'd7, "halt_reach");
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("halt_state", {29'd0, state}, 32'd7);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_m_en", {31'd0, m_en}, 32'd0);
            chk("halt_pc", pc, 32'd4);
        end
        reset = 1'b0;
        @(negedge clock);
        chk("halt_rst_pc", pc, 32'd0);
        chk("halt_rst_state", {29'd0, state}, 32'd0);
        chk("halt_rst_halted", {31'd0, halted}, 32'd0);

        // Reset during the memory wait of a store
        poke(8'h00, enc_m(OP_ST, 4'd15, 4'd0, 16'h00B0));
        poke(8'hB0, 32'h11223344);
        reset = 1'b1;
        wait_state(3'd2, "st_reach_exec");
        m_ready = 1'b0;
        @(negedge clock);
        chk("st_wait_state", {29'd0, state}, 32'd3);
        chk("st_wait_rw", {31'd0, m_rw}, 32'd0);
        chk("st_wait_addr", {16'd0, m_addr}, 32'hB0);
        chk("st_wait_wdata", m_wdata, 32'd4);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_m_en", {31'd0, m_en}, 32'd0);
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_addr", {16'd0, m_addr}, 32'd0);
        chk("abort_wdata", m_wdata, 32'd0);
        chk("abort_pc", pc, 32'd0);
        chk("abort_mem", rd_word(8'hB0), 32'h11223344);
        any_nz = 1'b0;
        for (int i = 0; i < 15; i++) any_nz |= (dut.regs_r[i] != 32'd0);
        chk("abort_regs", {31'd0, any_nz}, 32'd0);
        m_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
